// File: rtl/reg_dump_scanner.sv
// rtl/reg_dump_scanner.sv - walks the CPU debug register port and streams each value out
//
// Purpose: on start, steps reg_sel from FIRST_REG to LAST_REG, lets each index
// settle, captures reg_data and presents it as a tagged word with a valid/ready
// handshake. Optional macro REG_DUMP_PC_EN appends a PC word (tag 32) after the
// last register.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             scan request, sampled only while idle
//   reg_sel           register index driven to the CPU debug read port
//   reg_data          CPU register value for reg_sel
//   pc_in             CPU program counter (used only with REG_DUMP_PC_EN)
//   out_valid/ready   output word handshake
//   out_idx           word tag: 0-31 register index, 32 PC
//   out_data          captured value
//   busy              high whenever a scan is in progress
//   done              one-cycle pulse at the end of a completed scan
module reg_dump_scanner #(
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_idx,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [4:0]    FIRST_SEL = 5'(FIRST_REG);
  localparam logic [4:0]    LAST_SEL  = 5'(LAST_REG);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    EMIT,
`ifdef REG_DUMP_PC_EN
    PC,
`endif
    DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    reg_sel_n;
  logic          out_valid_n;
  logic [5:0]    out_idx_n;
  logic [31:0]   out_data_n;

`ifndef REG_DUMP_PC_EN
  logic unused_pc;
  assign unused_pc = ^pc_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_sel   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      reg_sel   <= reg_sel_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_data  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    reg_sel_n   = reg_sel;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_data_n  = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          reg_sel_n = FIRST_SEL;
          cnt_n     = SETTLE_LD;
          state_n   = SETTLE;
        end
      end
      SETTLE: begin
        // Counter runs down to zero and the capture happens on the edge after
        // that, so the first word appears SETTLE_CYC+1 edges after start.
        if (cnt == '0) begin
          out_data_n  = reg_data;
          out_idx_n   = {1'b0, reg_sel};
          out_valid_n = 1'b1;
          state_n     = EMIT;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          if (reg_sel < LAST_SEL) begin
            reg_sel_n = reg_sel + 5'd1;
            cnt_n     = SETTLE_LD;
            state_n   = SETTLE;
          end else begin
`ifdef REG_DUMP_PC_EN
            state_n = PC;
`else
            state_n = DONE;
`endif
          end
        end
      end
`ifdef REG_DUMP_PC_EN
      PC: begin
        // First cycle in PC captures the program counter; later cycles wait
        // for the consumer to take it.
        if (!out_valid) begin
          out_data_n  = pc_in;
          out_idx_n   = 6'd32;
          out_valid_n = 1'b1;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = DONE;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb/tb_reg_dump_scanner.sv - self-checking bench for reg_dump_scanner
module tb_reg_dump_scanner;

`ifdef REG_DUMP_PC_EN
  localparam int NW = 32;
`else
  localparam int NW = 31;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [31:0] pc_val = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic [4:0]  reg_sel2;
  logic [31:0] reg_data2;
  logic        out_valid2;
  logic        ready2 = 1'b1;
  logic [5:0]  out_idx2;
  logic [31:0] out_data2;
  logic        busy2;
  logic        done2;

  logic [31:0] regfile [32];
  logic [5:0]  got_idx[$];
  logic [31:0] got_data[$];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign reg_data  = regfile[reg_sel];
  assign reg_data2 = 32'h2000_0000 + {27'd0, reg_sel2};

  reg_dump_scanner dut (
    .clk(clk), .rst(rst), .start(start), .reg_sel(reg_sel), .reg_data(reg_data),
    .pc_in(pc_val), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  reg_dump_scanner #(.FIRST_REG(3), .LAST_REG(5), .SETTLE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .reg_sel(reg_sel2), .reg_data(reg_data2),
    .pc_in(32'h0000_0040), .out_valid(out_valid2), .out_ready(ready2), .out_idx(out_idx2),
    .out_data(out_data2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first word 10 cycles,
  // 3: always ready with random extra start pulses
  task automatic run_scan(input int mode, output int n_done, output int latency,
                          output int stab_err, output int model_err);
    logic [5:0]  m_idx[$];
    logic [31:0] m_data[$];
    logic        pv, pr;
    logic [5:0]  pidx;
    logic [31:0] pdata;
    logic [4:0]  psel;
    int          e, stall, k;
    bit          fin;
    for (int i = 1; i <= 31; i++) begin
      m_idx.push_back(6'(i));
      m_data.push_back(regfile[i]);
    end
`ifdef REG_DUMP_PC_EN
    m_idx.push_back(6'd32);
    m_data.push_back(pc_val);
`endif
    got_idx.delete();
    got_data.delete();
    n_done = 0; latency = -1; stab_err = 0; model_err = 0;
    pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0; psel = '0; stall = 0; fin = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    while (!fin && e < 4000) begin
      if (out_valid && latency < 0) latency = e;
      if (done) begin
        n_done++;
        fin = 1'b1;
      end
      if (pv && !pr && !(out_valid && out_idx == pidx && out_data == pdata && reg_sel == psel))
        stab_err++;
      if (!fin) begin
        case (mode)
          1: out_ready = 1'($urandom_range(0, 1));
          2: begin
            if (out_valid && got_idx.size() == 0 && stall < 10) begin
              out_ready = 1'b0;
              stall++;
            end else begin
              out_ready = 1'b1;
            end
          end
          3: begin
            out_ready = 1'b1;
            start = ($urandom_range(0, 3) == 0);
          end
          default: out_ready = 1'b1;
        endcase
        if (out_valid && out_ready) begin
          k = got_idx.size();
          if (k >= m_idx.size() || out_idx != m_idx[k] || out_data != m_data[k])
            model_err++;
          got_idx.push_back(out_idx);
          got_data.push_back(out_data);
        end
        pv = out_valid; pr = out_ready; pidx = out_idx; pdata = out_data; psel = reg_sel;
        tick();
        e++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!fin) model_err++;
    if (got_idx.size() != m_idx.size()) model_err++;
    if (mode == 2 && stall != 10) stab_err++;
  endtask

  typedef struct {
    int          mode;
    logic [31:0] base;
    logic [31:0] pc;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          nd, lat, se, me, e, lat2, n2, err2, last_hs, done_at, seen_done;
    logic [5:0]  exp2_idx[$];
    logic [31:0] exp2_data[$];
    logic [31:0] v;

    vecs[0] = '{0, 32'h1000_0000, 32'h0000_0040, 32'h1000_0001, 32'h1000_001F};
    vecs[1] = '{2, 32'hA500_0000, 32'h1234_5678, 32'hA500_0001, 32'hA500_001F};
    vecs[2] = '{3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_001F};
    vecs[3] = '{1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'hFFFF_FFF1, 32'h0000_000F};

    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + 32'(i);

    // reset state
    tick(); tick();
    check("rst_reg_sel", reg_sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // table-driven full scans
    foreach (vecs[t]) begin
      for (int i = 0; i < 32; i++) regfile[i] = vecs[t].base + 32'(i);
      pc_val = vecs[t].pc;
      run_scan(vecs[t].mode, nd, lat, se, me);
      check($sformatf("v%0d_words", t), got_idx.size(), NW);
      check($sformatf("v%0d_done_count", t), nd, 1);
      check($sformatf("v%0d_latency", t), lat, 3);
      check($sformatf("v%0d_stable", t), se, 0);
      check($sformatf("v%0d_model", t), me, 0);
      check($sformatf("v%0d_first_idx", t), got_idx.size() > 0 ? got_idx[0] : 6'h3F, 1);
      check($sformatf("v%0d_first_data", t), got_data.size() > 0 ? got_data[0] : 32'hx, vecs[t].exp_first);
      v = got_data.size() > 30 ? got_data[30] : 32'hx;
      check($sformatf("v%0d_last_reg_data", t), v, vecs[t].exp_last);
`ifdef REG_DUMP_PC_EN
      check($sformatf("v%0d_pc_idx", t), got_idx.size() > 31 ? got_idx[31] : 6'h0, 32);
      check($sformatf("v%0d_pc_data", t), got_data.size() > 31 ? got_data[31] : 32'hx, vecs[t].pc);
`endif
      tick();
      check($sformatf("v%0d_busy_after", t), busy, 0);
      check($sformatf("v%0d_done_after", t), done, 0);
    end

    // randomized scans against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      pc_val = $urandom;
      run_scan(($urandom_range(0, 1) == 1) ? 1 : 3, nd, lat, se, me);
      check($sformatf("rnd%0d_model", r), me, 0);
      check($sformatf("rnd%0d_done_count", r), nd, 1);
      check($sformatf("rnd%0d_stable", r), se, 0);
      tick();
    end

    // reset mid-scan while reg_sel is 7
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + 32'(i);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    seen_done = 0;
    while (reg_sel != 5'd7 && e < 500) begin
      if (done) seen_done++;
      tick();
      e++;
    end
    check("midrst_reached_sel7", reg_sel, 7);
    rst = 1'b1;
    #1;
    check("midrst_reg_sel", reg_sel, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick();
    if (done) seen_done++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    run_scan(0, nd, lat, se, me);
    check("midrst_restart_first_idx", got_idx.size() > 0 ? got_idx[0] : 6'h3F, 1);
    check("midrst_restart_model", me, 0);
    tick();

    // narrow configuration: regs 3..5, one settle cycle
    exp2_idx = '{6'd3, 6'd4, 6'd5};
    exp2_data = '{32'h2000_0003, 32'h2000_0004, 32'h2000_0005};
`ifdef REG_DUMP_PC_EN
    exp2_idx.push_back(6'd32);
    exp2_data.push_back(32'h0000_0040);
`endif
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    e = 0; lat2 = -1; n2 = 0; err2 = 0; last_hs = -10; done_at = -1;
    while (e < 100 && done_at < 0) begin
      if (out_valid2 && lat2 < 0) lat2 = e;
      if (done2) begin
        done_at = e;
      end else if (out_valid2) begin
        if (n2 >= exp2_idx.size() || out_idx2 != exp2_idx[n2] || out_data2 != exp2_data[n2])
          err2++;
        n2++;
        last_hs = e;
      end
      tick();
      e++;
    end
    check("narrow_latency", lat2, 2);
    check("narrow_words", n2, exp2_idx.size());
    check("narrow_model", err2, 0);
    check("narrow_done_gap", done_at - last_hs, 1);
    check("narrow_busy_after", busy2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
